// File: rtl/alu_issue_stage.sv
// RV32I decode-and-issue stage: decodes R/I/LUI arithmetic ops, reads operands
// combinationally and holds one ALU beat in a valid/ready output register.
module alu_issue_stage #(
  parameter int ALU_WIDTH = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  input  logic [31:0]          instr,
  output logic                 instr_ready,
  output logic [4:0]           rs1_addr,
  output logic [4:0]           rs2_addr,
  input  logic [ALU_WIDTH-1:0] rs1_data,
  input  logic [ALU_WIDTH-1:0] rs2_data,
  output logic                 alu_valid,
  input  logic                 alu_ready,
  output logic [2:0]           ALUSel,
  output logic                 func7,
  output logic [ALU_WIDTH-1:0] Op1,
  output logic [ALU_WIDTH-1:0] Op2,
  output logic [4:0]           rd,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] illegal_count
);
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef struct packed {
    logic [2:0]           sel;
    logic                 f7;
    logic [ALU_WIDTH-1:0] op1;
    logic [ALU_WIDTH-1:0] op2;
    logic [4:0]           rd;
    logic                 ill;
  } beat_t;

  beat_t                d, q;
  logic                 vld;
  logic                 legal;
  logic                 accept;
  logic [CNT_WIDTH-1:0] cnt;
  logic [6:0]           opc, f7h;
  logic [2:0]           f3;

  assign opc      = instr[6:0];
  assign f3       = instr[14:12];
  assign f7h      = instr[31:25];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  assign instr_ready = !vld || alu_ready;
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    d     = '0;
    legal = 1'b0;
    case (opc)
      OP_R: begin
        legal = (f7h == 7'd0) || (f7h == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
        d.sel = f3;
        d.f7  = instr[30];
        d.op1 = rs1_data;
        d.op2 = rs2_data;
      end
      OP_I: begin
        if (f3 == 3'b001)      legal = (f7h == 7'd0);
        else if (f3 == 3'b101) legal = (f7h == 7'd0) || (f7h == F7_ALT);
        else                   legal = 1'b1;
        d.sel = f3;
        d.f7  = (f3 == 3'b101) && instr[30];
        d.op1 = rs1_data;
        d.op2 = {{(ALU_WIDTH-12){instr[31]}}, instr[31:20]};
      end
      OP_LUI: begin
        legal = 1'b1;
        d.sel = 3'b001;
        d.f7  = 1'b1;  // ALU pass-through of Op2
        d.op2 = ALU_WIDTH'({instr[31:12], 12'b0});
      end
      default: legal = 1'b0;
    endcase
    if (legal) d.rd = instr[11:7];
    else begin
      d     = '0;
      d.ill = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      q   <= '0;
      cnt <= '0;
    end else if (accept) begin
      vld <= 1'b1;
      q   <= d;
      if (d.ill && cnt != '1) cnt <= cnt + 1'b1;
    end else if (alu_ready) begin
      vld <= 1'b0;
    end
  end

  assign alu_valid     = vld;
  assign ALUSel        = q.sel;
  assign func7         = q.f7;
  assign Op1           = q.op1;
  assign Op2           = q.op2;
  assign rd            = q.rd;
  assign illegal       = q.ill;
  assign illegal_count = cnt;
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-and-issue stage that drives the RV32I ALU. It accepts 32-bit instruction words over a valid/ready handshake and decodes the R-type, I-type and LUI arithmetic opcodes. It reads source operands through a combinational register-file port and presents `ALUSel`, `func7`, `Op1` and `Op2` to the ALU from a one-deep output register with its own valid/ready handshake. Illegal encodings are flagged and counted.

## Interface
- `ALU_WIDTH`, 32: operand width. Only 32 is supported.
- `CNT_WIDTH`, 8: width of the illegal-instruction counter.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  an instruction word is offered.
- `instr`  in  32  instruction word.
- `instr_ready`  out  1  stage accepts `instr` this cycle.
- `rs1_addr`  out  5  combinational, equals `instr[19:15]`.
- `rs2_addr`  out  5  combinational, equals `instr[24:20]`.
- `rs1_data`  in  ALU_WIDTH  register-file read data for `rs1_addr`, same cycle.
- `rs2_data`  in  ALU_WIDTH  register-file read data for `rs2_addr`, same cycle.
- `alu_valid`  out  1  output register holds a beat.
- `alu_ready`  in  1  downstream consumes the beat.
- `ALUSel`  out  3  ALU operation select.
- `func7`  out  1  ALU variant bit.
- `Op1`, `Op2`  out  ALU_WIDTH  ALU operands.
- `rd`  out  5  destination register.
- `illegal`  out  1  the beat came from an unsupported encoding.
- `illegal_count`  out  CNT_WIDTH  saturating count of illegal beats.

## Operation
- Accept condition: `instr_valid && instr_ready`.
- `instr_ready = !alu_valid || alu_ready`. This is a single pipeline register with no skid buffer.
- On accept, all output fields load from the decode. `alu_valid` becomes 1.
- If `alu_valid && alu_ready` and no accept occurs, `alu_valid` becomes 0. The field values then hold.
- R-type, opcode 0110011:
  - `ALUSel=instr[14:12]`, `func7=instr[30]`, `Op1=rs1_data`, `Op2=rs2_data`.
  - Legal only if `instr[31:25]` is 0000000, or is 0100000 with funct3 000 or 101.
- I-type, opcode 0010011:
  - `ALUSel=funct3`, `Op1=rs1_data`, `Op2` = sign-extended `instr[31:20]`.
  - `func7=instr[30]` only when funct3 is 101; otherwise `func7=0`.
  - Shifts (funct3 001/101): `instr[31:25]` must be 0000000. For funct3 101 it may also be 0100000. Any other value is illegal.
- LUI, opcode 0110111:
  - `ALUSel=001`, `func7=1` (the ALU passes `Op2` through).
  - `Op1=0`, `Op2={instr[31:12],12'b0}`.
- `rd=instr[11:7]` for legal beats. rd=x0 is legal and is passed through.
- Any other opcode, or a violated funct7 rule, is illegal:
  - The beat is still accepted and issued.
  - `illegal=1`, `ALUSel=0`, `func7=0`, `Op1=0`, `Op2=0`, `rd=0`.
  - `illegal_count` increments on accept and saturates at all-ones.

## Timing
- Reset: `alu_valid`, `ALUSel`, `func7`, `Op1`, `Op2`, `rd`, `illegal` and `illegal_count` all clear to 0. `instr_ready` is then 1.
- Latency: an instruction accepted at edge N has its beat visible after edge N with `alu_valid=1`.
- Throughput: one instruction per cycle while `alu_ready=1`.
- Stall: while `alu_valid && !alu_ready`, `instr_ready=0` and all output fields are held stable.
- Simultaneous consume and accept in one cycle: the new beat replaces the old one and `alu_valid` stays 1.
- Reset while a beat is pending: the beat is discarded with no handshake. `illegal_count` clears.
- `rs*_addr` are purely combinational from `instr`, whether or not `instr_valid` is asserted.

## Test plan
- Single ADD:
  - Stimulus: `instr=0x002081B3`, rs1_data=5, rs2_data=7, `alu_ready=1`.
  - Response: the next cycle shows `alu_valid=1`, ALUSel=000, func7=0, Op1=5, Op2=7, rd=3.
- SUB and SRAI:
  - SUB `0x402081B3` gives func7=1.
  - SRAI `0x4050D193` gives ALUSel=101, func7=1, Op2=0x405 (sign-extended `instr[31:20]`).
  - ADDI `0xC0008193` gives func7=0 and Op2=0xFFFFFC00.
- LUI:
  - Stimulus: `0x123452B7`.
  - Response: ALUSel=001, func7=1, Op1=0, Op2=0x12345000, rd=5.
- Back-pressure:
  - Stimulus: issue ADD, hold `alu_ready=0` for 3 cycles while offering an XOR.
  - Response: `instr_ready=0` and the ADD fields are stable throughout. When `alu_ready` rises, the XOR is accepted in the same cycle and appears the following cycle.
- Illegal encodings:
  - Stimulus: offer `0x00000073`, then R-type with funct7=0100000 and funct3=100.
  - Response: two beats with illegal=1 and zeroed fields; `illegal_count` reaches 2.
  - Stimulus: with `CNT_WIDTH=2`, offer 5 illegal instructions.
  - Response: `illegal_count` saturates at 3.
- Reset mid-stall:
  - Stimulus: assert `rst` for one cycle while `alu_valid=1` and `alu_ready=0`.
  - Response: next cycle `alu_valid=0`, all outputs are 0, and `instr_ready=1`.
